mdu_issue: RTL and testbench
============================

Name: mdu_issue

Overview:
- Issue/hand-off stage directly upstream of the multiply/divide unit (`mdu`).
- Accepts RV32M instructions from the EX stage, latches operands and funct3, and drives the mdu valid/op/operand interface stably until the mdu reports ready.
- Stalls the pipeline meanwhile, returns the result to writeback as a one-cycle pulse, and enforces the mdu's required idle gap between operations.

Parameters:
- WIDTH, 32, operand/result width.
- GAP_CYCLES, 2, minimum cycles o_mdu_valid is held low between two operations (minimum legal value 2).

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset; synchronous, active-low
- i_ex_valid  in  1  EX stage holds a valid instruction
- i_ex_is_m  in  1  EX instruction is RV32M (opcode 0110011, funct7 0000001)
- i_ex_funct3  in  3  M-extension funct3
- i_ex_rs1  in  WIDTH  operand A
- i_ex_rs2  in  WIDTH  operand B
- i_ex_rd_addr  in  5  destination register
- i_flush  in  1  kill the current EX instruction (branch/trap)
- o_stall  out  1  hold IF/ID/EX
- o_mdu_valid  out  1  to mdu i_mdu_valid
- o_mdu_op  out  3  to mdu i_mdu_op
- o_mdu_rs1  out  WIDTH  to mdu i_mdu_rs1
- o_mdu_rs2  out  WIDTH  to mdu i_mdu_rs2
- i_mdu_ready  in  1  from mdu o_mdu_ready
- i_mdu_rd  in  WIDTH  from mdu o_mdu_rd
- o_wb_valid  out  1  result pulse to writeback
- o_wb_rd_addr  out  5  destination register of the result
- o_wb_data  out  WIDTH  result data
- o_busy  out  1  state != IDLE

Behaviour:
- Reset (i_rst=0 at a clock edge):
  - state=IDLE, drain counter=0.
  - o_mdu_valid=0, o_wb_valid=0.
  - o_mdu_op, o_mdu_rs1, o_mdu_rs2, o_wb_rd_addr, o_wb_data all 0.
  - Reset mid-operation abandons the op with no writeback.
- FSM states: IDLE, BUSY, DONE, KILL, DRAIN.
- IDLE:
  - On i_ex_valid & i_ex_is_m & !i_flush: latch funct3/rs1/rs2/rd_addr and go to BUSY.
  - o_mdu_valid=1 from the next cycle.
- BUSY:
  - o_mdu_valid=1; o_mdu_op and operands stay constant.
  - On i_mdu_ready: capture i_mdu_rd into o_wb_data, go to DONE.
  - On i_flush without ready: go to KILL.
  - If i_flush and i_mdu_ready coincide, the flush wins: go to DRAIN, no writeback.
- DONE (exactly 1 cycle):
  - o_mdu_valid=0, o_wb_valid=1, o_stall=0 so EX advances.
  - Next state DRAIN.
- KILL:
  - o_mdu_valid stays 1 until i_mdu_ready, because the mdu divider cannot be aborted.
  - The result is discarded; then go to DRAIN.
- DRAIN:
  - o_mdu_valid=0; the counter loads GAP_CYCLES-1 on entry and counts down; return to IDLE at 0.
  - Total valid-low gap is ≥ GAP_CYCLES including the DONE cycle when applicable.
  - This gap prevents stale ready from the mdu's internal done pipeline.
- o_stall (combinational):
  - = i_ex_valid & i_ex_is_m & !i_flush & (state != DONE).
  - An M instruction arriving during DRAIN/KILL stalls until IDLE, then issues.
  - Non-M instructions never stall.
- Latency:
  - Issue to o_mdu_valid: 1 cycle.
  - i_mdu_ready to o_wb_valid: 1 cycle.
  - Stall deasserts in the o_wb_valid cycle.
- Timing/path rules:
  - i_mdu_ready is ignored in IDLE, DONE and DRAIN.
  - No combinational path from i_mdu_* to o_mdu_*.
  - o_wb_data is held until the next capture.

Decomposition:
- Shared package `mdu_pkg`:
  - mdu state enum.
  - funct3 constants MUL=000, MULH=001, MULHSU=010, MULHU=011, DIV=100, DIVU=101, REM=110, REMU=111.
  - M_OPCODE, M_FUNCT7.
- No sub-module; the gap counter is inline.

Test Plan:
- MUL rs1=7, rs2=0xFFFFFFFD (−3): o_mdu_valid next cycle; o_wb_valid=1 once with data 0xFFFFFFEB; o_stall high throughout, low in the wb cycle.
- DIV rs1=0xFFFFFFEC (−20), rs2=3; bench mdu model with ready after 33 cycles: wb data 0xFFFFFFFA, rd_addr echoed; operands stable every BUSY cycle.
- Back-to-back MULHU then REM (0xFFFFFFFF×2, then 7%−2): o_mdu_valid low for ≥2 cycles between ops; second op stalls through DRAIN; results 0x00000001 then 0x00000001.
- i_flush 5 cycles into a DIVU: no o_wb_valid; o_mdu_valid stays high until ready; valid-low gap then IDLE; o_stall=0 for non-M instructions during KILL.
- i_flush in the same cycle as i_mdu_ready: no writeback; next state DRAIN.
- i_rst=0 mid-BUSY: next cycle o_mdu_valid=0, o_wb_valid=0, o_busy=0; a fresh MUL 3×4 after reset gives 0x0000000C.

Source files
------------

// File: rtl/mdu_pkg.sv
// ---------------------------------------------------------------------------
// mdu_pkg
// Definitions shared between the multiply/divide issue stage and anything
// else that talks to the mdu: issue FSM state type, RV32M funct3 encodings
// and the opcode/funct7 pair that identifies an M-extension instruction.
// ---------------------------------------------------------------------------
package mdu_pkg;

    // Issue-stage FSM states.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_BUSY  = 3'd1,
        ST_DONE  = 3'd2,
        ST_KILL  = 3'd3,
        ST_DRAIN = 3'd4
    } mdu_state_e;

    // RV32M funct3 encodings (also the mdu op code).
    localparam logic [2:0] MUL    = 3'b000;
    localparam logic [2:0] MULH   = 3'b001;
    localparam logic [2:0] MULHSU = 3'b010;
    localparam logic [2:0] MULHU  = 3'b011;
    localparam logic [2:0] DIV    = 3'b100;
    localparam logic [2:0] DIVU   = 3'b101;
    localparam logic [2:0] REM    = 3'b110;
    localparam logic [2:0] REMU   = 3'b111;

    // Major opcode and funct7 of every RV32M instruction.
    localparam logic [6:0] M_OPCODE = 7'b0110011;
    localparam logic [6:0] M_FUNCT7 = 7'b0000001;

endpackage : mdu_pkg

// File: rtl/mdu_issue.sv
// ---------------------------------------------------------------------------
// mdu_issue
// Hand-off stage between EX and the multiply/divide unit. An RV32M instruction
// in EX is latched, presented to the mdu with stable op/operands until the mdu
// answers, and the result is returned to writeback as a one-cycle pulse. The
// pipeline is stalled while the operation is outstanding, and o_mdu_valid is
// held low for a minimum gap between operations so a stale ready from the
// mdu's internal done pipeline can never be mistaken for a new result.
//
// Parameters
//   WIDTH       operand/result width
//   GAP_CYCLES  minimum valid-low cycles between operations (>= 2)
//
// Ports
//   i_clk, i_rst        clock; synchronous active-low reset
//   i_ex_valid          EX holds a valid instruction
//   i_ex_is_m           EX instruction is RV32M
//   i_ex_funct3         M-extension funct3 (becomes the mdu op)
//   i_ex_rs1, i_ex_rs2  operands
//   i_ex_rd_addr        destination register
//   i_flush             kill the current EX instruction
//   o_stall             hold IF/ID/EX
//   o_mdu_valid/op/rs1/rs2  request to the mdu
//   i_mdu_ready, i_mdu_rd   response from the mdu
//   o_wb_valid/rd_addr/data result pulse to writeback
//   o_busy              FSM is not idle
// ---------------------------------------------------------------------------
module mdu_issue
    import mdu_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int GAP_CYCLES = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_ex_valid,
    input  logic             i_ex_is_m,
    input  logic [2:0]       i_ex_funct3,
    input  logic [WIDTH-1:0] i_ex_rs1,
    input  logic [WIDTH-1:0] i_ex_rs2,
    input  logic [4:0]       i_ex_rd_addr,
    input  logic             i_flush,
    output logic             o_stall,
    output logic             o_mdu_valid,
    output logic [2:0]       o_mdu_op,
    output logic [WIDTH-1:0] o_mdu_rs1,
    output logic [WIDTH-1:0] o_mdu_rs2,
    input  logic             i_mdu_ready,
    input  logic [WIDTH-1:0] i_mdu_rd,
    output logic             o_wb_valid,
    output logic [4:0]       o_wb_rd_addr,
    output logic [WIDTH-1:0] o_wb_data,
    output logic             o_busy
);

    // The drain counter only ever holds GAP_CYCLES-1 down to 0.
    localparam int              CNT_W    = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(GAP_CYCLES - 1);

    mdu_state_e       state_q,   state_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic [2:0]       op_q,      op_d;
    logic [WIDTH-1:0] rs1_q,     rs1_d;
    logic [WIDTH-1:0] rs2_q,     rs2_d;
    logic [4:0]       rd_addr_q, rd_addr_d;
    logic [WIDTH-1:0] wb_data_q, wb_data_d;

    logic ex_m_req;

    // A live M instruction in EX that has not been killed this cycle.
    assign ex_m_req = i_ex_valid & i_ex_is_m & ~i_flush;

    always_comb begin
        // NOTE: every next-state value gets its hold default before the case,
        // so no branch can leave one unassigned and infer a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        rs1_d     = rs1_q;
        rs2_d     = rs2_q;
        rd_addr_d = rd_addr_q;
        wb_data_d = wb_data_q;

        case (state_q)
            ST_IDLE: begin
                if (ex_m_req) begin
                    op_d      = i_ex_funct3;
                    rs1_d     = i_ex_rs1;
                    rs2_d     = i_ex_rs2;
                    rd_addr_d = i_ex_rd_addr;
                    state_d   = ST_BUSY;
                end
            end

            ST_BUSY: begin
                // A flush beats a coincident ready: the result is dropped.
                if (i_flush) begin
                    if (i_mdu_ready) begin
                        state_d = ST_DRAIN;
                        cnt_d   = CNT_LOAD;
                    end else begin
                        state_d = ST_KILL;
                    end
                end else if (i_mdu_ready) begin
                    wb_data_d = i_mdu_rd;
                    state_d   = ST_DONE;
                end
            end

            ST_DONE: begin
                state_d = ST_DRAIN;
                cnt_d   = CNT_LOAD;
            end

            // The divider cannot be aborted, so keep requesting until it
            // answers and throw the answer away.
            ST_KILL: begin
                if (i_mdu_ready) begin
                    state_d = ST_DRAIN;
                    cnt_d   = CNT_LOAD;
                end
            end

            ST_DRAIN: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: the reset is synchronous, so i_rst is sampled at the edge and
    // stays out of the sensitivity list.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            rd_addr_q <= '0;
            wb_data_q <= '0;
        end else begin
            // NOTE: non-blocking assignments make every register sample the
            // pre-edge values, independent of statement order.
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            rs1_q     <= rs1_d;
            rs2_q     <= rs2_d;
            rd_addr_q <= rd_addr_d;
            wb_data_q <= wb_data_d;
        end
    end

    // mdu-facing outputs decode only registered state, so there is no
    // combinational path from i_mdu_* back to o_mdu_*.
    assign o_mdu_valid  = (state_q == ST_BUSY) || (state_q == ST_KILL);
    assign o_mdu_op     = op_q;
    assign o_mdu_rs1    = rs1_q;
    assign o_mdu_rs2    = rs2_q;

    assign o_wb_valid   = (state_q == ST_DONE);
    assign o_wb_rd_addr = rd_addr_q;
    assign o_wb_data    = wb_data_q;

    // Released in DONE so EX advances exactly in the writeback cycle.
    assign o_stall      = ex_m_req & (state_q != ST_DONE);
    assign o_busy       = (state_q != ST_IDLE);

endmodule : mdu_issue

// File: tb/tb_mdu_issue.sv
// ---------------------------------------------------------------------------
// tb_mdu_issue
// Self-checking bench for mdu_issue. The bench plays both EX and the mdu:
// results come from a behavioural RV32M reference function, and the handshake
// timing is checked against the issue/writeback/gap rules of the stage.
// ---------------------------------------------------------------------------
module tb_mdu_issue;
    import mdu_pkg::*;

    localparam int WIDTH = 32;
    localparam int GAP   = 2;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_ex_valid;
    logic        i_ex_is_m;
    logic [2:0]  i_ex_funct3;
    logic [31:0] i_ex_rs1;
    logic [31:0] i_ex_rs2;
    logic [4:0]  i_ex_rd_addr;
    logic        i_flush;
    logic        o_stall;
    logic        o_mdu_valid;
    logic [2:0]  o_mdu_op;
    logic [31:0] o_mdu_rs1;
    logic [31:0] o_mdu_rs2;
    logic        i_mdu_ready;
    logic [31:0] i_mdu_rd;
    logic        o_wb_valid;
    logic [4:0]  o_wb_rd_addr;
    logic [31:0] o_wb_data;
    logic        o_busy;

    always #5 i_clk = ~i_clk;

    mdu_issue #(.WIDTH(WIDTH), .GAP_CYCLES(GAP)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_ex_valid   (i_ex_valid),
        .i_ex_is_m    (i_ex_is_m),
        .i_ex_funct3  (i_ex_funct3),
        .i_ex_rs1     (i_ex_rs1),
        .i_ex_rs2     (i_ex_rs2),
        .i_ex_rd_addr (i_ex_rd_addr),
        .i_flush      (i_flush),
        .o_stall      (o_stall),
        .o_mdu_valid  (o_mdu_valid),
        .o_mdu_op     (o_mdu_op),
        .o_mdu_rs1    (o_mdu_rs1),
        .o_mdu_rs2    (o_mdu_rs2),
        .i_mdu_ready  (i_mdu_ready),
        .i_mdu_rd     (i_mdu_rd),
        .o_wb_valid   (o_wb_valid),
        .o_wb_rd_addr (o_wb_rd_addr),
        .o_wb_data    (o_wb_data),
        .o_busy       (o_busy)
    );

    int total = 0;
    int bad   = 0;

    // Gap / drain trackers, updated once per sampled cycle.
    int          gap_low;
    bit          have_prev;
    bit          prev_valid;
    int          drain_seen;
    bit          expect_drain;
    logic [31:0] last_result;

    // RV32M reference semantics, including divide-by-zero and overflow.
    function automatic logic [31:0] ref_m(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] b);
        longint      sa, sb, ua, ub;
        logic [63:0] p;
        int          sq;
        sa = $signed({{32{a[31]}}, a});
        sb = $signed({{32{b[31]}}, b});
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (f3)
            MUL:    begin p = sa * sb; return p[31:0];  end
            MULH:   begin p = sa * sb; return p[63:32]; end
            MULHSU: begin p = sa * ub; return p[63:32]; end
            MULHU:  begin p = ua * ub; return p[63:32]; end
            DIV: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                sq = $signed(a) / $signed(b);
                return sq;
            end
            DIVU: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                return a / b;
            end
            REM: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                sq = $signed(a) % $signed(b);
                return sq;
            end
            default: begin
                if (b == 32'd0) return a;
                return a % b;
            end
        endcase
    endfunction

    task automatic clear_trackers();
        gap_low      = 0;
        have_prev    = 1'b0;
        prev_valid   = 1'b0;
        drain_seen   = 0;
        expect_drain = 1'b0;
    endtask

    // Checks the valid-low gap before every new request and the exact length
    // of each drain window (GAP cycles busy with valid low).
    task automatic note_cycle();
        if (o_mdu_valid) begin
            if (!prev_valid && have_prev) begin
                total++;
                if (gap_low < GAP) begin
                    bad++;
                    $display("FAIL valid_gap: low %0d cycles, need >= %0d", gap_low, GAP);
                end
            end
            have_prev = 1'b1;
            gap_low   = 0;
        end else begin
            gap_low++;
        end
        prev_valid = o_mdu_valid;

        if (o_wb_valid) begin
            expect_drain = 1'b1;
            drain_seen   = 0;
        end else if (o_busy && !o_mdu_valid) begin
            expect_drain = 1'b1;
            drain_seen++;
        end else if (!o_busy && expect_drain) begin
            total++;
            if (drain_seen != GAP) begin
                bad++;
                $display("FAIL drain_len: %0d cycles, need %0d", drain_seen, GAP);
            end
            expect_drain = 1'b0;
            drain_seen   = 0;
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
        note_cycle();
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (o_busy && n < 60) begin
            total++;
            if (o_wb_valid !== 1'b0) begin
                bad++;
                $display("FAIL idle_wait_wb: got wb_valid=%b want 0", o_wb_valid);
            end
            tick();
            n++;
        end
        total++;
        if (o_busy !== 1'b0) begin
            bad++;
            $display("FAIL idle_timeout: busy=%b after %0d cycles", o_busy, n);
        end
    endtask

    // One complete M operation: present in EX, answer as the mdu after `lat`
    // request cycles, check the writeback pulse. Returns in the first cycle
    // after writeback with EX empty.
    task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input int lat, input bit from_idle);
        logic [31:0] exp;
        int          n;
        exp          = ref_m(f3, a, b);
        i_mdu_ready  = 1'b0;
        i_flush      = 1'b0;
        i_ex_valid   = 1'b1;
        i_ex_is_m    = 1'b1;
        i_ex_funct3  = f3;
        i_ex_rs1     = a;
        i_ex_rs2     = b;
        i_ex_rd_addr = rd;
        #1;
        n = 0;
        while (!o_mdu_valid && n < 60) begin
            total++;
            if (o_stall !== 1'b1) begin
                bad++;
                $display("FAIL issue_stall: got %b want 1 (wait cycle %0d)", o_stall, n);
            end
            tick();
            n++;
        end
        total++;
        if (o_mdu_valid !== 1'b1) begin
            bad++;
            $display("FAIL issue_timeout: mdu_valid=%b after %0d cycles", o_mdu_valid, n);
            i_ex_valid = 1'b0;
            return;
        end
        if (from_idle) begin
            total++;
            if (n != 1) begin
                bad++;
                $display("FAIL issue_latency: got %0d cycles want 1", n);
            end
        end

        for (int k = 1; k <= lat; k++) begin
            total++;
            if (o_mdu_valid !== 1'b1 || o_mdu_op !== f3 || o_mdu_rs1 !== a || o_mdu_rs2 !== b) begin
                bad++;
                $display("FAIL busy_hold: got valid=%b op=%0d rs1=%h rs2=%h want 1 %0d %h %h",
                         o_mdu_valid, o_mdu_op, o_mdu_rs1, o_mdu_rs2, f3, a, b);
            end
            total++;
            if (o_stall !== 1'b1 || o_wb_valid !== 1'b0) begin
                bad++;
                $display("FAIL busy_stall: got stall=%b wb_valid=%b want 1 0", o_stall, o_wb_valid);
            end
            if (k == lat) begin
                i_mdu_ready = 1'b1;
                i_mdu_rd    = exp;
            end else begin
                i_mdu_rd    = $urandom;
            end
            tick();
            i_mdu_ready = 1'b0;
            i_mdu_rd    = $urandom;
        end

        #1;
        total++;
        if (o_wb_valid !== 1'b1) begin
            bad++;
            $display("FAIL wb_pulse: got %b want 1", o_wb_valid);
        end
        total++;
        if (o_wb_data !== exp) begin
            bad++;
            $display("FAIL wb_data: op=%0d a=%h b=%h got %h want %h", f3, a, b, o_wb_data, exp);
        end
        total++;
        if (o_wb_rd_addr !== rd) begin
            bad++;
            $display("FAIL wb_rd_addr: got %0d want %0d", o_wb_rd_addr, rd);
        end
        total++;
        if (o_mdu_valid !== 1'b0 || o_stall !== 1'b0) begin
            bad++;
            $display("FAIL done_handoff: got mdu_valid=%b stall=%b want 0 0", o_mdu_valid, o_stall);
        end
        last_result = exp;

        tick();
        i_ex_valid = 1'b0;
        i_ex_is_m  = 1'b0;
        total++;
        if (o_wb_valid !== 1'b0 || o_mdu_valid !== 1'b0 || o_wb_data !== exp) begin
            bad++;
            $display("FAIL after_done: got wb_valid=%b mdu_valid=%b data=%h want 0 0 %h",
                     o_wb_valid, o_mdu_valid, o_wb_data, exp);
        end
    endtask

    task automatic test_reset();
        i_rst        = 1'b0;
        i_ex_valid   = 1'b0;
        i_ex_is_m    = 1'b0;
        i_ex_funct3  = 3'd0;
        i_ex_rs1     = 32'd0;
        i_ex_rs2     = 32'd0;
        i_ex_rd_addr = 5'd0;
        i_flush      = 1'b0;
        i_mdu_ready  = 1'b0;
        i_mdu_rd     = 32'd0;
        clear_trackers();
        tick();
        tick();
        total++;
        if (o_busy !== 1'b0 || o_mdu_valid !== 1'b0 || o_wb_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_ctrl: got busy=%b mdu_valid=%b wb_valid=%b want 0 0 0",
                     o_busy, o_mdu_valid, o_wb_valid);
        end
        total++;
        if (o_mdu_op !== 3'd0 || o_mdu_rs1 !== 32'd0 || o_mdu_rs2 !== 32'd0 ||
            o_wb_rd_addr !== 5'd0 || o_wb_data !== 32'd0) begin
            bad++;
            $display("FAIL reset_data: got op=%0d rs1=%h rs2=%h rd=%0d data=%h want all 0",
                     o_mdu_op, o_mdu_rs1, o_mdu_rs2, o_wb_rd_addr, o_wb_data);
        end
        i_rst = 1'b1;
        clear_trackers();
        last_result = 32'd0;
        // A stray ready while idle must be ignored.
        i_mdu_ready = 1'b1;
        i_mdu_rd    = 32'hDEAD_BEEF;
        tick();
        tick();
        i_mdu_ready = 1'b0;
        total++;
        if (o_busy !== 1'b0 || o_wb_valid !== 1'b0 || o_wb_data !== 32'd0) begin
            bad++;
            $display("FAIL idle_ready_ignored: got busy=%b wb_valid=%b data=%h want 0 0 0",
                     o_busy, o_wb_valid, o_wb_data);
        end
    endtask

    task automatic test_mul();
        do_op(MUL, 32'd7, 32'hFFFF_FFFD, 5'd10, 3, 1'b1);
        wait_idle();
    endtask

    task automatic test_div();
        do_op(DIV, 32'hFFFF_FFEC, 32'd3, 5'd17, 33, 1'b1);
        wait_idle();
    endtask

    task automatic test_back_to_back();
        do_op(MULHU, 32'hFFFF_FFFF, 32'd2, 5'd3, 4, 1'b1);
        // Ready during DRAIN must not produce a writeback.
        i_mdu_ready = 1'b1;
        i_mdu_rd    = 32'h1234_5678;
        tick();
        i_mdu_ready = 1'b0;
        total++;
        if (o_wb_valid !== 1'b0 || o_mdu_valid !== 1'b0 || o_wb_data !== last_result) begin
            bad++;
            $display("FAIL drain_ready_ignored: got wb_valid=%b mdu_valid=%b data=%h want 0 0 %h",
                     o_wb_valid, o_mdu_valid, o_wb_data, last_result);
        end
        do_op(REM, 32'd7, 32'hFFFF_FFFE, 5'd4, 5, 1'b0);
        wait_idle();
    endtask

    task automatic test_flush_kill();
        logic [31:0] a, b;
        a            = $urandom;
        b            = $urandom | 32'd1;
        i_ex_valid   = 1'b1;
        i_ex_is_m    = 1'b1;
        i_ex_funct3  = DIVU;
        i_ex_rs1     = a;
        i_ex_rs2     = b;
        i_ex_rd_addr = 5'd9;
        i_flush      = 1'b0;
        tick();
        for (int k = 1; k <= 5; k++) begin
            total++;
            if (o_mdu_valid !== 1'b1 || o_mdu_op !== DIVU) begin
                bad++;
                $display("FAIL kill_busy: got valid=%b op=%0d want 1 %0d", o_mdu_valid, o_mdu_op, DIVU);
            end
            if (k == 5) i_flush = 1'b1;
            tick();
        end
        i_flush = 1'b0;
        for (int k = 6; k <= 20; k++) begin
            // EX now holds a non-M instruction, later an M one.
            i_ex_valid   = 1'b1;
            i_ex_is_m    = (k >= 14);
            i_ex_funct3  = 3'($urandom_range(0, 7));
            i_ex_rs1     = $urandom;
            i_ex_rs2     = $urandom;
            i_ex_rd_addr = 5'($urandom_range(0, 31));
            i_mdu_rd     = $urandom;
            #1;
            total++;
            if (o_mdu_valid !== 1'b1 || o_mdu_op !== DIVU || o_mdu_rs1 !== a || o_mdu_rs2 !== b) begin
                bad++;
                $display("FAIL kill_hold: got valid=%b op=%0d rs1=%h rs2=%h want 1 %0d %h %h",
                         o_mdu_valid, o_mdu_op, o_mdu_rs1, o_mdu_rs2, DIVU, a, b);
            end
            total++;
            if (o_stall !== i_ex_is_m || o_wb_valid !== 1'b0 || o_busy !== 1'b1) begin
                bad++;
                $display("FAIL kill_stall: got stall=%b wb=%b busy=%b want %b 0 1",
                         o_stall, o_wb_valid, o_busy, i_ex_is_m);
            end
            if (k == 20) i_mdu_ready = 1'b1;
            tick();
            i_mdu_ready = 1'b0;
        end
        i_ex_valid = 1'b0;
        i_ex_is_m  = 1'b0;
        total++;
        if (o_mdu_valid !== 1'b0 || o_wb_valid !== 1'b0 || o_busy !== 1'b1 || o_wb_data !== last_result) begin
            bad++;
            $display("FAIL kill_drain: got valid=%b wb=%b busy=%b data=%h want 0 0 1 %h",
                     o_mdu_valid, o_wb_valid, o_busy, o_wb_data, last_result);
        end
        wait_idle();
    endtask

    task automatic test_flush_ready();
        i_ex_valid   = 1'b1;
        i_ex_is_m    = 1'b1;
        i_ex_funct3  = MUL;
        i_ex_rs1     = 32'd5;
        i_ex_rs2     = 32'd6;
        i_ex_rd_addr = 5'd22;
        i_flush      = 1'b0;
        tick();
        tick();
        tick();
        i_flush     = 1'b1;
        i_mdu_ready = 1'b1;
        i_mdu_rd    = 32'd30;
        tick();
        i_flush     = 1'b0;
        i_mdu_ready = 1'b0;
        i_ex_valid  = 1'b0;
        i_ex_is_m   = 1'b0;
        total++;
        if (o_mdu_valid !== 1'b0 || o_wb_valid !== 1'b0 || o_busy !== 1'b1 || o_wb_data !== last_result) begin
            bad++;
            $display("FAIL flush_ready: got valid=%b wb=%b busy=%b data=%h want 0 0 1 %h",
                     o_mdu_valid, o_wb_valid, o_busy, o_wb_data, last_result);
        end
        wait_idle();
    endtask

    task automatic test_reset_mid();
        i_ex_valid   = 1'b1;
        i_ex_is_m    = 1'b1;
        i_ex_funct3  = DIV;
        i_ex_rs1     = 32'd100;
        i_ex_rs2     = 32'd7;
        i_ex_rd_addr = 5'd2;
        tick();
        tick();
        tick();
        i_rst = 1'b0;
        tick();
        total++;
        if (o_mdu_valid !== 1'b0 || o_wb_valid !== 1'b0 || o_busy !== 1'b0 || o_wb_data !== 32'd0) begin
            bad++;
            $display("FAIL reset_mid: got valid=%b wb=%b busy=%b data=%h want 0 0 0 0",
                     o_mdu_valid, o_wb_valid, o_busy, o_wb_data);
        end
        i_rst      = 1'b1;
        i_ex_valid = 1'b0;
        i_ex_is_m  = 1'b0;
        clear_trackers();
        last_result = 32'd0;
        tick();
        do_op(MUL, 32'd3, 32'd4, 5'd8, 2, 1'b1);
        wait_idle();
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    task automatic test_random();
        bit chained;
        chained = 1'b0;
        for (int i = 0; i < 40; i++) begin
            do_op(3'($urandom_range(0, 7)), pick_operand(), pick_operand(),
                  5'($urandom_range(0, 31)), int'($urandom_range(1, 40)), !chained);
            chained = ($urandom_range(0, 1) == 1);
            if (!chained) wait_idle();
        end
        wait_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_back_to_back();
        test_flush_kill();
        test_flush_ready();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_mdu_issue
